// File: rtl/mdu_pkg.sv
// mdu_pkg: definitions shared by the EXU multiply/divide blocks.
//   XLEN        operand/result width
//   DIV_ITER_D  radix-2 iterations for a 64-bit divide
//   DIV_ITER_W  radix-2 iterations for a 32-bit (W form) divide
//   ALL_ONES    divide-by-zero quotient
//   MIN_D/MIN_W most negative value, full width and sign-extended 32-bit
//   state_e     request/response FSM states
package mdu_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned DIV_ITER_D = 64;
    localparam int unsigned DIV_ITER_W = 32;
    localparam int unsigned CNT_W      = $clog2(DIV_ITER_D + 1);

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_D    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W    = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/divider_if.sv
// divider_if: request/response bundle of the iterative divider.
//   master (requester): drives in_valid, flush, divw, div_signed, dividend,
//                       divisor; observes out_ready, out_valid, quotient,
//                       remainder.
//   slave  (divider):   the reverse directions.
interface divider_if;
    import mdu_pkg::*;

    logic            in_valid;
    logic            flush;
    logic            divw;
    logic            div_signed;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            out_ready;
    logic            out_valid;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;

    modport master (
        output in_valid, flush, divw, div_signed, dividend, divisor,
        input  out_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  in_valid, flush, divw, div_signed, dividend, divisor,
        output out_ready, out_valid, quotient, remainder
    );

endinterface

// File: rtl/divider_prep.sv
// div_prep: combinational operand preparation for the divider.
//   divw_i      1 = 32-bit op, operands truncated to the low 32 bits
//   signed_i    1 = signed operands
//   dividend_i  raw dividend
//   divisor_i   raw divisor
//   a_abs_o     |dividend| (as-width, upper bits zero for W ops)
//   b_abs_o     |divisor|  (as-width, upper bits zero for W ops)
//   a_ext_o     dividend as-width, sign-extended for W ops (div-by-zero rem)
//   q_neg_o     quotient must be negated
//   r_neg_o     remainder must be negated
//   zero_o      divisor is zero (as-width)
//   ovf_o       signed MIN / -1
//   small_o     |dividend| < |divisor| (only with DIVIDER_EARLY_OUT_EN)
module div_prep
    import mdu_pkg::*;
(
    input  logic            divw_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] a_abs_o,
    output logic [XLEN-1:0] b_abs_o,
    output logic [XLEN-1:0] a_ext_o,
    output logic            q_neg_o,
    output logic            r_neg_o,
    output logic            zero_o,
    output logic            ovf_o
`ifdef DIVIDER_EARLY_OUT_EN
    ,
    output logic            small_o
`endif
);

    logic            a_sign;
    logic            b_sign;
    logic [XLEN-1:0] a_s;
    logic [XLEN-1:0] b_s;

    always_comb begin
        a_sign = divw_i ? dividend_i[31] : dividend_i[XLEN-1];
        b_sign = divw_i ? divisor_i[31]  : divisor_i[XLEN-1];

        // Operands reinterpreted at the op width: W forms extend bit 31 only
        // when signed, so unsigned W operands stay below 2^32.
        a_s = divw_i ? {{(XLEN-32){signed_i & a_sign}}, dividend_i[31:0]} : dividend_i;
        b_s = divw_i ? {{(XLEN-32){signed_i & b_sign}}, divisor_i[31:0]}  : divisor_i;

        a_abs_o = (signed_i & a_sign) ? -a_s : a_s;
        b_abs_o = (signed_i & b_sign) ? -b_s : b_s;
        a_ext_o = divw_i ? {{(XLEN-32){dividend_i[31]}}, dividend_i[31:0]} : dividend_i;

        q_neg_o = signed_i & (a_sign ^ b_sign);
        r_neg_o = signed_i & a_sign;
        zero_o  = (b_s == '0);
        ovf_o   = signed_i & (a_s == (divw_i ? MIN_W : MIN_D)) & (b_s == ALL_ONES);
`ifdef DIVIDER_EARLY_OUT_EN
        small_o = (a_abs_o < b_abs_o);
`endif
    end

endmodule

// File: rtl/divider.sv
// divider: iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU
// and their W forms, sharing the multiplier's request/response handshake.
//   clock  single clock, all state on posedge
//   reset  synchronous, active-low
//   bus    divider_if.slave: in_valid/flush/divw/div_signed/dividend/divisor
//          in; out_ready/out_valid/quotient/remainder out
// Latency is N+1 cycles from accept (N = 64, or 32 for W forms).
// Build option DIVIDER_EARLY_OUT_EN: divide-by-zero, signed overflow and
// |dividend| < |divisor| go straight to DONE and complete one cycle after
// accept.
module divider
    import mdu_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    divider_if.slave  bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  div_q, div_d;
    logic [XLEN-1:0]  aext_q, aext_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             w_q, w_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [XLEN-1:0]  p_a_abs, p_b_abs, p_a_ext;
    logic             p_q_neg, p_r_neg, p_zero, p_ovf;
`ifdef DIVIDER_EARLY_OUT_EN
    logic             p_small;
`endif

    logic             accept;
    logic [CNT_W-1:0] n_last;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;
    logic [XLEN-1:0]  qn, rn, q_res, r_res;

    div_prep u_prep (
        .divw_i     (bus.divw),
        .signed_i   (bus.div_signed),
        .dividend_i (bus.dividend),
        .divisor_i  (bus.divisor),
        .a_abs_o    (p_a_abs),
        .b_abs_o    (p_b_abs),
        .a_ext_o    (p_a_ext),
        .q_neg_o    (p_q_neg),
        .r_neg_o    (p_r_neg),
        .zero_o     (p_zero),
        .ovf_o      (p_ovf)
`ifdef DIVIDER_EARLY_OUT_EN
        ,
        .small_o    (p_small)
`endif
    );

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        aext_d  = aext_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        w_d     = w_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        accept  = bus.in_valid & (state_q == IDLE) & ~bus.flush;
        n_last  = w_q ? CNT_W'(DIV_ITER_W - 1) : CNT_W'(DIV_ITER_D - 1);
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, div_q};

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // W operands sit in the top half of quo so that 32 shifts
                    // consume them and leave the quotient in the low half.
                    quo_d   = bus.divw ? (p_a_abs << (XLEN - 32)) : p_a_abs;
                    rem_d   = '0;
                    div_d   = p_b_abs;
                    aext_d  = p_a_ext;
                    qneg_d  = p_q_neg;
                    rneg_d  = p_r_neg;
                    w_d     = bus.divw;
                    zero_d  = p_zero;
                    ovf_d   = p_ovf;
                    cnt_d   = '0;
                    state_d = CALC;
`ifdef DIVIDER_EARLY_OUT_EN
                    // Preload the trivial result (q=0, r=|a|); zero/overflow
                    // results are substituted at the output anyway.
                    if (p_zero | p_ovf | p_small) begin
                        quo_d   = '0;
                        rem_d   = p_a_abs;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (!diff[XLEN]) begin
                    rem_d = diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = shifted[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == n_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.flush) begin
            state_d = IDLE;
        end
    end

    always_comb begin : result
        qn = qneg_q ? -quo_q : quo_q;
        rn = rneg_q ? -rem_q : rem_q;

        if (zero_q) begin
            q_res = ALL_ONES;
            r_res = aext_q;
        end else if (ovf_q) begin
            q_res = w_q ? MIN_W : MIN_D;
            r_res = '0;
        end else if (w_q) begin
            q_res = {{(XLEN-32){qn[31]}}, qn[31:0]};
            r_res = {{(XLEN-32){rn[31]}}, rn[31:0]};
        end else begin
            q_res = qn;
            r_res = rn;
        end

        bus.out_ready = (state_q == IDLE);
        bus.out_valid = (state_q == DONE) & ~bus.flush;
        bus.quotient  = bus.out_valid ? q_res : '0;
        bus.remainder = bus.out_valid ? r_res : '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            aext_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            w_q     <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            aext_q  <= aext_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            w_q     <= w_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
